// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Upstream pushes bytes with a valid/ready handshake. The FSM drains the FIFO
// and streams frames onto a single idle-high serial line. When a byte is
// waiting at the end of a stop bit, the next start bit follows with no gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. Frames then take 11 bit times.
//
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   BAUD       - line rate in bit/s; each bit lasts CLK_FREQ/BAUD cycles
//   FIFO_DEPTH - input FIFO entries (power of two, >= 2)
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset; aborts any frame in flight
//   data      - byte to transmit
//   valid_in  - data is valid this cycle
//   ready_out - FIFO not full; a byte is accepted when valid_in && ready_out
//   tx        - serial output, idle high, registered
//   busy      - a frame is on the line or the FIFO holds bytes
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_CNT - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign ready_out = (count != FULL_COUNT);
    assign push      = valid_in && ready_out;
    // The FSM takes a byte either from idle or at the last cycle of a stop bit.
    assign pop       = (count != '0) &&
                       ((state == IDLE) || (state == STOP && baud_cnt == '0));
    assign busy      = (state != IDLE) || (count != '0);

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud_cnt  <= BAUD_RELOAD;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        tx       <= shift_reg[0];
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_RELOAD;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= ^shift_reg;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == '0) begin
                        tx       <= 1'b1;
                        baud_cnt <= BAUD_RELOAD;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            // Back-to-back frame: start bit follows immediately.
                            shift_reg <= mem[rd_ptr];
                            baud_cnt  <= BAUD_RELOAD;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with BAUD_CNT = 10.
// A frame-timing model predicts tx/busy/ready_out every cycle. A line
// decoder recovers bytes from tx. Literal expectations pin the model.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int BC       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, tx, busy;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data(data), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit armed = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Model: a queue of accepted bytes plus the offset into the current frame.
    logic [7:0] mq[$];
    logic [7:0] mcur;
    bit         mact = 0;
    int         moff = 0;
    logic       exp_tx, exp_busy, exp_ready;

    initial begin
        bit push_ok;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                mact  = 0;
                armed = 1;
            end else begin
                push_ok = valid_in && (mq.size() < DEPTH);
                if (!mact) begin
                    if (mq.size() > 0) begin
                        mcur = mq.pop_front();
                        mact = 1;
                        moff = 0;
                    end
                end else if (moff == FL - 1) begin
                    if (mq.size() > 0) begin
                        mcur = mq.pop_front();
                        moff = 0;
                    end else begin
                        mact = 0;
                    end
                end else begin
                    moff++;
                end
                if (push_ok) mq.push_back(data);
            end
            exp_tx    = mact ? line_bit(mcur, moff / BC) : 1'b1;
            exp_busy  = mact || (mq.size() != 0);
            exp_ready = (mq.size() < DEPTH);
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("tx", tx, exp_tx);
                chk("busy", busy, exp_busy);
                chk("ready_out", ready_out, exp_ready);
            end
        end
    end

    // Line decoder: samples each bit in the middle of its period.
    logic [7:0] dec_q[$];
    logic       par_q[$];
    initial begin
        bit d_act = 0;
        int d_off = 0;
        int j;
        logic [7:0] d_byte = 8'h00;
        logic d_par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d_act = 0;
            end else begin
                if (!d_act) begin
                    if (armed && tx === 1'b0) begin
                        d_act = 1;
                        d_off = 0;
                    end
                end else begin
                    d_off++;
                end
                if (d_act) begin
                    j = d_off / BC;
                    if (d_off % BC == 5) begin
                        if (j >= 1 && j <= 8) d_byte[j-1] = tx;
                        if (NB == 11 && j == 9) d_par = tx;
                        if (j == NB - 1) begin
                            chk("stop_bit", tx, 1);
                            dec_q.push_back(d_byte);
                            par_q.push_back(d_par);
                        end
                    end
                    if (d_off == FL - 1) d_act = 0;
                end
            end
        end
    end

    task automatic wait_idle(output int t_end);
        for (int i = 0; i < 5000 && busy !== 1'b0; i++) tick();
        chk("idle_timeout", busy, 0);
        t_end = cyc;
    endtask

    task automatic push_seq(input logic [7:0] b[$]);
        foreach (b[i]) begin
            data = b[i];
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic chk_dec(input string nm, input logic [7:0] e[$]);
        chk({nm, "_count"}, dec_q.size(), e.size());
        foreach (e[i]) if (i < dec_q.size()) chk(nm, dec_q[i], e[i]);
    endtask

    initial begin
        int pat[11];
        int t0, t1, idx, first_block, lows;
        bit r;
        logic [7:0] six[$];

        // Reset state
        tick();
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready_out, 1);
        tick();
        rst = 1'b0;

        // Single byte 0x55: fall one cycle after acceptance, each level 10 cycles
`ifdef UART_TX_PARITY_EN
        pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
        dec_q.delete(); par_q.delete();
        data = 8'h55; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("single_tx_before_fall", tx, 1);
        chk("single_busy_after_push", busy, 1);
        tick();
        chk("single_fall", tx, 0);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < BC; c++) begin
                chk("single_level", tx, pat[b]);
                tick();
            end
        end
        chk("single_end_tx", tx, 1);
        chk("single_end_busy", busy, 0);
        chk_dec("single_byte", '{8'h55});

        // Back-to-back frames
        tick(); tick();
        dec_q.delete(); par_q.delete();
        t0 = cyc + 1;
        push_seq('{8'hA3, 8'h0F, 8'hFF});
        wait_idle(t1);
        chk("b2b_total_cycles", t1 - (t0 + 1), 3 * FL);
        chk_dec("b2b_byte", '{8'hA3, 8'h0F, 8'hFF});

        // Full FIFO: hold valid with 6 bytes
        tick();
        dec_q.delete(); par_q.delete();
        six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idx = 0;
        first_block = -1;
        for (int i = 0; i < 2000 && idx < 6; i++) begin
            data = six[idx];
            valid_in = 1'b1;
            r = ready_out;
            if (!r && first_block < 0) first_block = idx;
            tick();
            if (r) idx++;
        end
        valid_in = 1'b0;
        chk("full_accepted_before_block", first_block, 5);
        chk("full_all_accepted", idx, 6);
        wait_idle(t1);
        chk_dec("full_byte", six);

        // Reset during bit 3 of 0x81 with two bytes queued
        tick();
        dec_q.delete(); par_q.delete();
        push_seq('{8'h81, 8'h5A, 8'hC3});
        for (int i = 0; i < 33; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", ready_out, 1);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
            tick();
        end
        chk("rst_line_quiet", lows, 0);
        chk("rst_no_bytes", dec_q.size(), 0);

        // Frame length and parity bit
        dec_q.delete(); par_q.delete();
        t0 = cyc + 1;
        push_seq('{8'h07});
        wait_idle(t1);
        chk("frame07_cycles", t1 - (t0 + 1), NB * 10);
        chk_dec("frame07_byte", '{8'h07});
        dec_q.delete();
        push_seq('{8'h03});
        wait_idle(t1);
        chk_dec("frame03_byte", '{8'h03});
`ifdef UART_TX_PARITY_EN
        if (par_q.size() == 2) begin
            chk("parity_07", par_q[0], 1);
            chk("parity_03", par_q[1], 0);
        end else begin
            chk("parity_count", par_q.size(), 2);
        end
`endif

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter with a small input FIFO: 8N1 frames, LSB first, on a single serial line to the host (FTDI RX).
Sits at the output side of the design and streams result bytes back to the laptop.
A valid/ready handshake lets upstream logic push bursts without tracking baud timing.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD_CNT = CLK_FREQ/BAUD (integer division) clock cycles per bit
FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
data  input  8  byte to transmit
valid_in  input  1  data is valid this cycle
ready_out  output  1  FIFO can accept; a transfer occurs when valid_in && ready_out at a rising edge
tx  output  1  serial line, idle high, registered output
busy  output  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Reset (synchronous; takes effect on the edge where rst=1):
  - tx=1, ready_out=1, busy=0, FSM=IDLE.
  - FIFO pointers and count cleared, so contents are discarded.
  - A reset mid-frame aborts the frame: tx returns to 1 on that edge, and no partial bits are sent afterwards.
- FIFO:
  - ready_out = (count != FIFO_DEPTH). This is combinational from count and does not depend on valid_in.
  - Push when valid_in && ready_out.
  - When full, a push is refused even if a pop occurs in the same cycle. No look-ahead.
  - A push and a pop in the same cycle (not full) are both performed, and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (PARITY added under the macro).
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into shift_reg, load baud_cnt=BAUD_CNT-1, drive tx<=0, and go to START.
  - START: hold tx=0. When baud_cnt==0, drive tx<=shift_reg[0], set bit_idx=0, reload baud_cnt, and go to DATA. Otherwise decrement baud_cnt.
  - DATA: hold the current bit. When baud_cnt==0:
    - if bit_idx==7, drive tx<=1 and go to STOP;
    - else increment bit_idx and drive tx<=shift_reg[bit_idx+1].
    - Reload baud_cnt in both cases.
  - STOP: hold tx=1. When baud_cnt==0:
    - if the FIFO is non-empty, pop, drive tx<=0 and go to START (back-to-back, no idle gap);
    - else go to IDLE.
- Timing:
  - Every bit, including start and stop, is exactly BAUD_CNT cycles.
  - A frame is 10*BAUD_CNT cycles.
  - Latency: a byte pushed at edge k into an empty FIFO with the FSM in IDLE makes tx fall at edge k+1.
- baud_cnt width is $clog2(BAUD_CNT); it never underflows.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
UART_TX_PARITY_EN:
- When defined, a PARITY state is inserted between DATA and STOP.
- It lasts BAUD_CNT cycles and drives the even-parity bit (^shift_reg), so the total count of ones across data and parity is even.
- A frame is then 11*BAUD_CNT cycles.
- When undefined, there is no PARITY state and frames are 8N1 at 10*BAUD_CNT cycles.

Test Plan:
Use CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_CNT=10.
- Single byte: push 0x55 after reset -> tx falls 1 cycle after acceptance; line sequence 0,1,0,1,0,1,0,1,0,1 with each level held exactly 10 cycles; then tx=1 and busy=0 at cycle 100.
- Back-to-back: push 0xA3, 0x0F, 0xFF on consecutive cycles -> three contiguous frames, 300 cycles total, with no idle cycles between a stop bit and the next start bit; decoded bytes match in order.
- Full FIFO (depth 4): hold valid_in=1 with 6 bytes while the first frame is on the line -> ready_out drops after 5 accepted bytes (1 in shift_reg, 4 in FIFO); the 6th byte is held until the first pop; all 6 bytes are transmitted in order.
- Reset mid-frame: assert rst for 1 cycle during bit 3 of 0x81 with 2 bytes queued -> tx=1 on that edge, busy=0, ready_out=1; the line stays high afterwards, and no queued bytes are sent.
- Parity (UART_TX_PARITY_EN): push 0x07 -> parity bit 1, stop bit 1, frame 110 cycles. Push 0x03 -> parity bit 0.
